// File: rtl/time_display_driver.sv
// time_display_driver: converts binary seconds/minutes (0-59) to BCD with a
// sequential double-dabble engine and scans four common-anode 7-segment digits
// showing MM.SS, with refresh timing, segment encoding, dp and blanking.
// Ports: clk_in/reset_in (async active-low); sec_in/min_in binary values;
//        blank_in turns all anodes off; an_out digit enables (bit0 = sec ones
//        .. bit3 = min tens); seg_out {g..a}; dp_out; bcd_valid_out set once
//        the first conversion has committed.
module time_display_driver #(
  parameter int REFRESH_DIV      = 100000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [7:0] sec_in,
  input  logic [7:0] min_in,
  input  logic       blank_in,
  output logic [3:0] an_out,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       bcd_valid_out
);

  localparam int              CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0]      AN_OFF  = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic            DP_OFF  = SEG_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       sec_shadow, min_shadow;
  logic [7:0]       sec_sr, min_sr;
  logic [7:0]       sec_acc, min_acc;
  logic             sec_ovr, min_ovr;
  logic [2:0]       shift_cnt;
  logic [3:0][3:0]  dig;
  logic             sec_dash, min_dash;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic             capture;

  // One double-dabble step: correct each nibble that would overflow past 9
  // after doubling, then shift in the next binary bit.
  function automatic logic [7:0] dd_step(input logic [7:0] acc, input logic b);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = acc[3:0];
    hi = acc[7:4];
    if (lo >= 4'd5) lo = lo + 4'd3;
    if (hi >= 4'd5) hi = hi + 4'd3;
    return 8'({hi, lo, b});
  endfunction

  // A new conversion starts when the inputs differ from what was last
  // captured, or unconditionally until the first result has been committed.
  assign capture = (state == IDLE) &&
                   (({min_in, sec_in} != {min_shadow, sec_shadow}) || !bcd_valid_out);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = SHIFT;
      SHIFT:   if (shift_cnt == 3'd7) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion datapath. Both fields shift in parallel from working copies so
  // the shadow stays intact for change detection.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      sec_shadow    <= '0;
      min_shadow    <= '0;
      sec_sr        <= '0;
      min_sr        <= '0;
      sec_acc       <= '0;
      min_acc       <= '0;
      sec_ovr       <= 1'b0;
      min_ovr       <= 1'b0;
      shift_cnt     <= '0;
      dig           <= '0;
      sec_dash      <= 1'b0;
      min_dash      <= 1'b0;
      bcd_valid_out <= 1'b0;
    end else if (capture) begin
      sec_shadow <= sec_in;
      min_shadow <= min_in;
      sec_sr     <= sec_in;
      min_sr     <= min_in;
      sec_acc    <= '0;
      min_acc    <= '0;
      sec_ovr    <= (sec_in > 8'd59);
      min_ovr    <= (min_in > 8'd59);
      shift_cnt  <= '0;
    end else if (state == SHIFT) begin
      sec_acc   <= dd_step(sec_acc, sec_sr[7]);
      min_acc   <= dd_step(min_acc, min_sr[7]);
      sec_sr    <= {sec_sr[6:0], 1'b0};
      min_sr    <= {min_sr[6:0], 1'b0};
      shift_cnt <= shift_cnt + 3'd1;
    end else if (state == COMMIT) begin
      dig[0]        <= sec_acc[3:0];
      dig[1]        <= sec_acc[7:4];
      dig[2]        <= min_acc[3:0];
      dig[3]        <= min_acc[7:4];
      sec_dash      <= sec_ovr;
      min_dash      <= min_ovr;
      bcd_valid_out <= 1'b1;
    end
  end

  // Free-running refresh counter; the digit index steps on each wrap.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_MAX) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  logic [3:0] cur_dig;
  logic       cur_dash;
  logic [6:0] pat;
  logic [3:0] an_on;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  always_comb begin
    cur_dig  = dig[digit_idx];
    cur_dash = digit_idx[1] ? min_dash : sec_dash;
    pat      = 7'b1111111;
    if (cur_dash) begin
      pat = 7'b0111111;
    end else begin
      case (cur_dig)
        4'd0:    pat = 7'b1000000;
        4'd1:    pat = 7'b1111001;
        4'd2:    pat = 7'b0100100;
        4'd3:    pat = 7'b0110000;
        4'd4:    pat = 7'b0011001;
        4'd5:    pat = 7'b0010010;
        4'd6:    pat = 7'b0000010;
        4'd7:    pat = 7'b1111000;
        4'd8:    pat = 7'b0000000;
        4'd9:    pat = 7'b0010000;
        default: pat = 7'b1111111;
      endcase
    end
    an_on   = (bcd_valid_out && !blank_in) ? (4'b0001 << digit_idx) : 4'b0000;
    an_nxt  = ANODE_ACTIVE_LOW ? ~an_on : an_on;
    seg_nxt = SEG_ACTIVE_LOW ? pat : ~pat;
    // dp sits between the minutes and seconds pairs, i.e. on minutes-ones.
    dp_nxt  = (digit_idx == 2'd2) ? ~DP_OFF : DP_OFF;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      an_out  <= AN_OFF;
      seg_out <= SEG_OFF;
      dp_out  <= DP_OFF;
    end else begin
      an_out  <= an_nxt;
      seg_out <= seg_nxt;
      dp_out  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_time_display_driver.sv
// Bench for time_display_driver with REFRESH_DIV = 4: directed scenarios plus
// randomized seconds/minutes/blank stimulus, checked each cycle against a
// behavioural model of the display (decimal arithmetic, edge counting).
module tb_time_display_driver;

  localparam int DIV = 4;

  logic       clk_in   = 1'b0;
  logic       reset_in = 1'b1;
  logic [7:0] sec_in   = 8'd0;
  logic [7:0] min_in   = 8'd0;
  logic       blank_in = 1'b0;
  logic [3:0] an_out;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       bcd_valid_out;

  time_display_driver #(
    .REFRESH_DIV     (DIV),
    .ANODE_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .sec_in       (sec_in),
    .min_in       (min_in),
    .blank_in     (blank_in),
    .an_out       (an_out),
    .seg_out      (seg_out),
    .dp_out       (dp_out),
    .bcd_valid_out(bcd_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};
  localparam logic [6:0] DASH = 7'b0111111;

  // Model state
  int         m_cyc;
  int         m_busy;
  int         m_cap_sec;
  int         m_cap_min;
  bit         m_valid;
  logic [6:0] m_pat [4];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_valid;
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] field_pat(input int v, input bit tens);
    if (v > 59) return DASH;
    return tens ? seg_tbl[v / 10] : seg_tbl[v % 10];
  endfunction

  task automatic model_reset();
    m_cyc     = 0;
    m_busy    = 0;
    m_cap_sec = 0;
    m_cap_min = 0;
    m_valid   = 1'b0;
    for (int i = 0; i < 4; i++) m_pat[i] = seg_tbl[0];
    e_an    = 4'hF;
    e_seg   = 7'h7F;
    e_dp    = 1'b1;
    e_valid = 1'b0;
  endtask

  // One rising edge: outputs show what was scanned before the edge, then the
  // conversion (9 edges from capture to visible digits) advances.
  task automatic model_step();
    int idx;
    logic [3:0] one;
    idx   = (m_cyc / DIV) % 4;
    one   = 4'b0001 << idx;
    e_an  = (m_valid && !blank_in) ? ~one : 4'hF;
    e_seg = m_pat[idx];
    e_dp  = (idx != 2);
    m_cyc++;
    if (m_busy == 0) begin
      if (int'(sec_in) != m_cap_sec || int'(min_in) != m_cap_min || !m_valid) begin
        m_cap_sec = int'(sec_in);
        m_cap_min = int'(min_in);
        m_busy    = 9;
      end
    end else begin
      m_busy--;
      if (m_busy == 0) begin
        m_pat[0] = field_pat(m_cap_sec, 1'b0);
        m_pat[1] = field_pat(m_cap_sec, 1'b1);
        m_pat[2] = field_pat(m_cap_min, 1'b0);
        m_pat[3] = field_pat(m_cap_min, 1'b1);
        m_valid  = 1'b1;
      end
    end
    e_valid = m_valid;
  endtask

  // Inputs only change at posedge+2, so the model sees what the DUT samples.
  task automatic tick();
    @(posedge clk_in);
    if (reset_in) model_step();
    #2;
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("an_out", an_out, e_an);
      chk("seg_out", seg_out, e_seg);
      chk("dp_out", dp_out, e_dp);
      chk("bcd_valid_out", bcd_valid_out, e_valid);
    end
  end

  task automatic wait_an(input logic [3:0] want, input string name, input logic [6:0] seg_exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (an_out == want) begin
        seen = 1'b1;
        chk(name, seg_out, seg_exp);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: anode %b never seen, last %b", name, want, an_out);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, an_out, 4'hF);
    chk({tag, "_seg"}, seg_out, 7'h7F);
    chk({tag, "_dp"}, dp_out, 1'b1);
    chk({tag, "_valid"}, bcd_valid_out, 1'b0);
  endtask

  initial begin
    model_reset();
    #1 reset_in = 1'b0;
    #1 chk_reset_vals("reset");
    chk_en = 1'b1;
    repeat (2) tick();
    reset_in = 1'b1;

    // First conversion after reset: edges numbered from 0, commit at edge 9.
    for (int e = 0; e <= 9; e++) begin
      tick();
      chk("first_valid", bcd_valid_out, 32'(e >= 9));
      if (e <= 8) chk("first_an_off", an_out, 4'hF);
    end
    repeat (8) tick();
    wait_an(4'b1011, "zero_min1_seg", 7'b1000000);
    chk("zero_dp_on", dp_out, 1'b0);
    wait_an(4'b1110, "zero_sec1_seg", 7'b1000000);
    chk("zero_dp_off", dp_out, 1'b1);

    // 12:58 -> 12:59
    min_in = 8'd12;
    sec_in = 8'd58;
    repeat (15) tick();
    sec_in = 8'd59;
    repeat (15) tick();
    wait_an(4'b1110, "s59_ones", 7'b0010000);
    wait_an(4'b1101, "s59_tens", 7'b0010010);
    wait_an(4'b1011, "m12_ones", 7'b0100100);
    wait_an(4'b0111, "m12_tens", 7'b1111001);

    // Change 3 cycles into SHIFT: old value commits, then the new one.
    sec_in = 8'd20;
    tick();
    repeat (3) tick();
    sec_in = 8'd21;
    repeat (30) tick();
    wait_an(4'b1110, "s21_ones", 7'b1111001);

    // Out-of-range seconds.
    sec_in = 8'd75;
    min_in = 8'd7;
    repeat (30) tick();
    wait_an(4'b1110, "s75_ones", 7'b0111111);
    wait_an(4'b1101, "s75_tens", 7'b0111111);
    wait_an(4'b1011, "m7_ones", 7'b1111000);
    wait_an(4'b0111, "m7_tens", 7'b1000000);

    // Blanking.
    blank_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("blank_an", an_out, 4'hF);
    end
    blank_in = 1'b0;
    repeat (10) tick();

    // Reset during SHIFT.
    sec_in = 8'd33;
    tick();
    repeat (3) tick();
    reset_in = 1'b0;
    model_reset();
    #1 chk_reset_vals("midshift_reset");
    repeat (3) tick();
    reset_in = 1'b1;
    repeat (30) tick();
    wait_an(4'b1101, "s33_tens", 7'b0110000);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(0, 11) == 0)
        sec_in = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(60, 255))
                                             : 8'($urandom_range(0, 59));
      if ($urandom_range(0, 29) == 0)
        min_in = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(60, 255))
                                             : 8'($urandom_range(0, 59));
      if ($urandom_range(0, 39) == 0) blank_in = ~blank_in;
    end
    blank_in = 1'b0;
    repeat (20) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
